multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum cycles spent waiting on mem_ready before a bus fault; legal range 1..255.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 instrucao  input  32  current instruction-register contents; sampled in DECODE and EXEC only.
REQ-005 zero  input  1  ALU zero flag; sampled in EXEC.
REQ-006 mem_ready  input  1  memory completion strobe; sampled in FETCH and MEM.
REQ-007 mem_read  output  1  memory read request.
REQ-008 mem_write  output  1  memory write request.
REQ-009 ir_write  output  1  one-cycle IR load strobe.
REQ-010 pc_write  output  1  one-cycle PC update strobe.
REQ-011 pc_src  output  1  0 = PC+4, 1 = PC+branch immediate.
REQ-012 reg_write  output  1  register-file write enable.
REQ-013 alu_src_b  output  1  0 = rs2, 1 = immediate.
REQ-014 alu_op  output  2  00 = add, 01 = sub, 10 = or, 11 = decode from funct3/funct7.
REQ-015 imm_sel  output  2  00 = I-type, 01 = S-type, 10 = B-type; drives the immediate generator.
REQ-016 mem_to_reg  output  1  write-back source: 1 = memory data, 0 = ALU result.
REQ-017 trap  output  1  sticky fault indicator.
REQ-018 fault_code  output  2  00 = none, 01 = illegal instruction, 10 = bus timeout.

Function
REQ-019 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP, encoded one-per-cycle and registered.
- Outputs are a Moore function of the state, except ir_write, pc_write and pc_src, which are qualified by inputs as stated below.
REQ-020 FETCH SHALL hold mem_read=1.
- On mem_ready=1: pulse ir_write=1 and pc_write=1 (pc_src=0), then go to DECODE.
- Otherwise stay in FETCH.
REQ-021 DECODE SHALL classify instrucao[6:0] together with funct3 (and funct7 for R-type).
- lb: 0000011 / 000. sb: 0100011 / 000. ori: 0010011 / 110. bne: 1100011 / 001. R-type: 0110011 with funct7 0000000 or 0100000.
- Any other encoding goes to TRAP with fault_code=01.
- Every legal encoding goes to EXEC.
REQ-022 EXEC SHALL drive the ALU per instruction class:
- lb/sb: alu_op=00, alu_src_b=1; imm_sel=00 for lb, 01 for sb.
- ori: alu_op=10, alu_src_b=1, imm_sel=00.
- R-type: alu_op=11, alu_src_b=0.
- bne: alu_op=01, alu_src_b=0, imm_sel=10.
REQ-023 EXEC transitions:
- lb/sb go to MEM; ori and R-type go to WB.
- bne goes to FETCH, pulsing pc_write=1 with pc_src=1 only when zero=0.
REQ-024 MEM SHALL hold mem_read=1 for lb or mem_write=1 for sb until mem_ready=1.
- Then lb goes to WB and sb goes to FETCH.
REQ-025 WB SHALL assert reg_write=1 for exactly one cycle, with mem_to_reg=1 for lb and 0 otherwise, then go to FETCH.
REQ-026 A wait counter SHALL count consecutive cycles in FETCH or MEM with mem_ready=0.
- It clears on state entry and whenever mem_ready=1.
- Reaching TIMEOUT_CYCLES forces TRAP with fault_code=10.
REQ-027 TRAP SHALL be absorbing until reset.
- trap=1 and fault_code held; all request, strobe and enable outputs 0.
REQ-028 Latency with mem_ready=1 on the first sampled cycle:
- R-type/ori: 4 cycles. lb: 5 cycles. sb: 4 cycles. bne: 3 cycles.
REQ-029 When mem_ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES, completion SHALL win.
REQ-030 mem_read and mem_write SHALL never be asserted together.

Reset
REQ-031 Asserting reset SHALL immediately force state=FETCH, wait counter=0, trap=0 and fault_code=00, and drive all strobes and enables to 0, even mid-transfer.
- mem_read rises one cycle after reset deasserts.
- reset takes priority over all other events.

Structure
REQ-032 A shared package SHALL hold:
- the state enumeration;
- the opcode and funct3 constants (LB, SB, ORI, BNE, RTYPE);
- the alu_op, imm_sel and fault_code encodings, reused by the immediate generator and the ALU decoder.
REQ-033 The combinational instruction classifier SHALL be a sub-module named instr_classify, outputting a class code and a legal flag.

Verification
REQ-034 ori x1,x0,0x5 (0x00506093), mem_ready always 1:
- states FETCH, DECODE, EXEC, WB; reg_write=1 in cycle 4 only; alu_op=10, imm_sel=00 in EXEC.
REQ-035 lb with mem_ready delayed 3 cycles in MEM:
- mem_read held 4 cycles; then WB with mem_to_reg=1; total 8 cycles.
REQ-036 bne, two runs:
- zero=0: pc_write=1 with pc_src=1 in EXEC.
- zero=1: no pc_write in EXEC, next state FETCH.
REQ-037 Instruction 0xFFFFFFFF:
- TRAP after DECODE; trap=1, fault_code=01; all outputs 0 for 20 further cycles.
REQ-038 mem_ready held 0 in FETCH with TIMEOUT_CYCLES=15:
- TRAP entered after 15 waiting cycles with fault_code=10.
- Repeat with mem_ready=1 on cycle 15: FETCH completes, no trap.
REQ-039 Reset asserted mid-MEM for sb:
- mem_write drops immediately; after release, FETCH with mem_read=1 on the next cycle.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// instruction classes, opcode/funct constants and datapath select codes.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_LB,
        C_SB,
        C_ORI,
        C_BNE,
        C_RTYPE
    } iclass_t;

    localparam logic [6:0] OP_LB    = 7'b0000011;
    localparam logic [6:0] OP_SB    = 7'b0100011;
    localparam logic [6:0] OP_ORI   = 7'b0010011;
    localparam logic [6:0] OP_BNE   = 7'b1100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_ORI = 3'b110;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_OR    = 2'b10,
        ALU_FUNCT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } imm_sel_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_BUS     = 2'b10
    } fault_t;

    // {alu_src_b, alu_op, imm_sel} presented while a class is in EXEC
    function automatic logic [4:0] exec_ctrl(input iclass_t c);
        case (c)
            C_LB:    return {1'b1, ALU_ADD, IMM_I};
            C_SB:    return {1'b1, ALU_ADD, IMM_S};
            C_ORI:   return {1'b1, ALU_OR, IMM_I};
            C_RTYPE: return {1'b0, ALU_FUNCT, IMM_I};
            C_BNE:   return {1'b0, ALU_SUB, IMM_B};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_instr_classify.sv
// Combinational instruction classifier: maps opcode/funct3/funct7 to an
// instruction class and flags any encoding outside the supported subset.
module instr_classify
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output iclass_t    iclass,
    output logic       legal
);

    always_comb begin
        iclass = C_NONE;
        case (opcode)
            OP_LB:    if (funct3 == F3_LB)  iclass = C_LB;
            OP_SB:    if (funct3 == F3_SB)  iclass = C_SB;
            OP_ORI:   if (funct3 == F3_ORI) iclass = C_ORI;
            OP_BNE:   if (funct3 == F3_BNE) iclass = C_BNE;
            OP_RTYPE: if (funct7 == F7_BASE || funct7 == F7_ALT) iclass = C_RTYPE;
            default:  iclass = C_NONE;
        endcase
        legal = (iclass != C_NONE);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky
// TRAP state for illegal instructions and memory-wait timeouts.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_sel,
    output logic        mem_to_reg,
    output logic        trap,
    output logic [1:0]  fault_code
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    iclass_t    cls;
    iclass_t    cls_next;
    logic       legal;
    logic [7:0] wait_cnt;
    logic       fetch_done;
    logic       branch_taken;
    logic       unused_instr;

    instr_classify u_classify (
        .opcode (instrucao[6:0]),
        .funct3 (instrucao[14:12]),
        .funct7 (instrucao[31:25]),
        .iclass (cls_next),
        .legal  (legal)
    );

    assign unused_instr = ^{instrucao[24:15], instrucao[11:7]};

    // FETCH only completes once its read request is actually on the bus,
    // which keeps the strobes quiet in the first cycle after reset.
    assign fetch_done   = (state == S_FETCH) && mem_read && mem_ready;
    assign branch_taken = (state == S_EXEC) && (cls == C_BNE) && !zero;
    assign ir_write     = fetch_done;
    assign pc_write     = fetch_done || branch_taken;
    assign pc_src       = branch_taken;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            cls        <= C_NONE;
            wait_cnt   <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            alu_src_b  <= 1'b0;
            alu_op     <= ALU_ADD;
            imm_sel    <= IMM_I;
            mem_to_reg <= 1'b0;
            trap       <= 1'b0;
            fault_code <= FAULT_NONE;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!mem_read) begin
                        mem_read <= 1'b1;
                    end else if (mem_ready) begin
                        state    <= S_DECODE;
                        mem_read <= 1'b0;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state      <= S_TRAP;
                        mem_read   <= 1'b0;
                        trap       <= 1'b1;
                        fault_code <= FAULT_BUS;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls <= cls_next;
                    if (legal) begin
                        state <= S_EXEC;
                        {alu_src_b, alu_op, imm_sel} <= exec_ctrl(cls_next);
                    end else begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        fault_code <= FAULT_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    {alu_src_b, alu_op, imm_sel} <= '0;
                    wait_cnt <= '0;
                    case (cls)
                        C_LB: begin
                            state    <= S_MEM;
                            mem_read <= 1'b1;
                        end
                        C_SB: begin
                            state     <= S_MEM;
                            mem_write <= 1'b1;
                        end
                        C_ORI, C_RTYPE: begin
                            state     <= S_WB;
                            reg_write <= 1'b1;
                        end
                        default: begin
                            state    <= S_FETCH;
                            mem_read <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        wait_cnt  <= '0;
                        if (cls == C_LB) begin
                            state      <= S_WB;
                            mem_read   <= 1'b0;
                            reg_write  <= 1'b1;
                            mem_to_reg <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            mem_read <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state      <= S_TRAP;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        trap       <= 1'b1;
                        fault_code <= FAULT_BUS;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    state      <= S_FETCH;
                    reg_write  <= 1'b0;
                    mem_to_reg <= 1'b0;
                    mem_read   <= 1'b1;
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes its
// expected output vector, which the negedge monitor pops and compares.
module tb_multicycle_control;

    localparam logic [14:0] MR   = 15'h4000;
    localparam logic [14:0] MW   = 15'h2000;
    localparam logic [14:0] IRW  = 15'h1000;
    localparam logic [14:0] PCW  = 15'h0800;
    localparam logic [14:0] PCS  = 15'h0400;
    localparam logic [14:0] RW   = 15'h0200;
    localparam logic [14:0] ASB  = 15'h0100;
    localparam logic [14:0] M2R  = 15'h0008;
    localparam logic [14:0] TRP  = 15'h0004;
    localparam logic [14:0] ALL  = 15'h7FFF;
    localparam logic [14:0] NX   = 15'h7E0F;
    localparam logic [14:0] RX   = 15'h7FCF;
    localparam logic [14:0] F1   = MR | IRW | PCW;
    localparam logic [14:0] ALU1 = 15'h0040;
    localparam logic [14:0] ALU2 = 15'h0080;
    localparam logic [14:0] ALU3 = 15'h00C0;
    localparam logic [14:0] IMM1 = 15'h0010;
    localparam logic [14:0] IMM2 = 15'h0020;
    localparam logic [14:0] FC1  = 15'h0001;
    localparam logic [14:0] FC2  = 15'h0002;

    localparam logic [31:0] I_ORI = 32'h00506093;
    localparam logic [31:0] I_LB  = 32'h00000083;
    localparam logic [31:0] I_SB  = 32'h00100023;
    localparam logic [31:0] I_BNE = 32'h00101463;
    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_SUB = 32'h403100B3;
    localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

    typedef struct {
        string       tag;
        logic [14:0] val;
        logic [14:0] mask;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instrucao = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, ir_write, pc_write, pc_src, reg_write;
    logic        alu_src_b, mem_to_reg, trap;
    logic [1:0]  alu_op, imm_sel, fault_code;
    logic [14:0] outs;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;

    multicycle_control #(.TIMEOUT_CYCLES(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .instrucao  (instrucao),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .mem_to_reg (mem_to_reg),
        .trap       (trap),
        .fault_code (fault_code)
    );

    assign outs = {mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
                   alu_src_b, alu_op, imm_sel, mem_to_reg, trap, fault_code};

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset || sb.size() > 0)
            check("rw_excl", {31'b0, mem_read & mem_write}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, {17'b0, outs & e.mask}, {17'b0, e.val & e.mask});
        end
    end

    // One clock cycle: drive inputs shortly after the edge, queue the expectation.
    task automatic cyc(input logic mr, input logic z, input logic [14:0] val,
                       input logic [14:0] mask, input string tag);
        @(posedge clock);
        #2;
        mem_ready = mr;
        zero      = z;
        sb.push_back('{tag, val, mask});
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        sb.push_back('{"rst", 15'h0, ALL});
        @(posedge clock);
        #2;
        reset = 1'b0;
        sb.push_back('{"rel", 15'h0, ALL});
    endtask

    initial begin
        #1 reset = 1'b1;
        do_reset();

        instrucao = I_ORI;
        cyc(1, 0, F1, NX, "ori_f");
        cyc(0, 0, 15'h0, NX, "ori_d");
        cyc(0, 0, ASB | ALU2, ALL, "ori_x");
        cyc(0, 0, RW, NX, "ori_wb");

        instrucao = I_LB;
        cyc(0, 0, MR, NX, "lb_fwait");
        cyc(1, 0, F1, NX, "lb_f");
        cyc(0, 0, 15'h0, NX, "lb_d");
        cyc(0, 0, ASB, ALL, "lb_x");
        for (int i = 0; i < 3; i++) cyc(0, 0, MR, NX, "lb_mwait");
        cyc(1, 0, MR, NX, "lb_mdone");
        cyc(0, 0, RW | M2R, NX, "lb_wb");

        instrucao = I_BNE;
        cyc(1, 0, F1, NX, "bne0_f");
        cyc(0, 0, 15'h0, NX, "bne0_d");
        cyc(0, 0, PCW | PCS | ALU1 | IMM2, ALL, "bne0_x");
        cyc(1, 1, F1, NX, "bne1_f");
        cyc(0, 1, 15'h0, NX, "bne1_d");
        cyc(0, 1, ALU1 | IMM2, ALL, "bne1_x");

        instrucao = I_ADD;
        cyc(1, 0, F1, NX, "add_f");
        cyc(0, 0, 15'h0, NX, "add_d");
        cyc(0, 0, ALU3, RX, "add_x");
        cyc(0, 0, RW, NX, "add_wb");
        instrucao = I_SUB;
        cyc(1, 0, F1, NX, "sub_f");
        cyc(0, 0, 15'h0, NX, "sub_d");
        cyc(0, 0, ALU3, RX, "sub_x");
        cyc(0, 0, RW, NX, "sub_wb");

        instrucao = I_SB;
        cyc(1, 0, F1, NX, "sb_f");
        cyc(0, 0, 15'h0, NX, "sb_d");
        cyc(0, 0, ASB | IMM1, ALL, "sb_x");
        cyc(1, 0, MW, NX, "sb_m");
        cyc(1, 0, F1, NX, "sb2_f");
        cyc(0, 0, 15'h0, NX, "sb2_d");
        cyc(0, 0, ASB | IMM1, ALL, "sb2_x");
        cyc(0, 0, MW, NX, "sb2_mwait");
        cyc(0, 0, MW, NX, "sb2_mwait");
        do_reset();
        cyc(0, 0, MR, NX, "rst_f");

        instrucao = I_BAD;
        cyc(1, 0, F1, NX, "ill_f");
        cyc(0, 0, 15'h0, NX, "ill_d");
        for (int i = 0; i < 20; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TRP | FC1, NX, "ill_trap");

        do_reset();
        for (int i = 0; i < 15; i++) cyc(0, 0, MR, NX, "to_wait");
        for (int i = 0; i < 3; i++) cyc(1, 0, TRP | FC2, NX, "to_trap");

        do_reset();
        instrucao = I_ORI;
        for (int i = 0; i < 14; i++) cyc(0, 0, MR, NX, "edge_wait");
        cyc(1, 0, F1, NX, "edge_done");
        cyc(0, 0, 15'h0, NX, "edge_d");
        cyc(0, 0, ASB | ALU2, ALL, "edge_x");
        cyc(0, 0, RW, NX, "edge_wb");

        instrucao = I_LB;
        cyc(1, 0, F1, NX, "lbto_f");
        cyc(0, 0, 15'h0, NX, "lbto_d");
        cyc(0, 0, ASB, ALL, "lbto_x");
        for (int i = 0; i < 15; i++) cyc(0, 0, MR, NX, "lbto_wait");
        for (int i = 0; i < 2; i++) cyc(0, 0, TRP | FC2, NX, "lbto_trap");

        @(negedge clock);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
